// File: rtl/timer_evt_ctrl_if.sv
// Event/trigger bus between the timer counter, the event block and the
// interrupt/status side. The master drives the counter samples; the slave returns events.
interface timer_evt_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
);
  localparam int NEV = NUM_CH + 2;

  logic                    en;
  logic                    updw;
  logic                    load;
  logic [WIDTH-1:0]        last_cnt;
  logic [WIDTH-1:0]        cnt;
  logic [NUM_CH*WIDTH-1:0] cmp_val;
  logic [NUM_CH-1:0]       cmp_en;
  logic [NEV-1:0]          sts_clr;
  logic [NEV-1:0]          irq_en;
  logic                    ovf_trig;
  logic                    udf_trig;
  logic [NUM_CH-1:0]       cmp_trig;
  logic [NEV-1:0]          evt_sts;
  logic [NEV-1:0]          evt_ovr;
  logic                    irq;

  modport master (
    output en, updw, load, last_cnt, cnt,
    output cmp_val, cmp_en, sts_clr, irq_en,
    input  ovf_trig, udf_trig, cmp_trig,
    input  evt_sts, evt_ovr, irq
  );

  modport slave (
    input  en, updw, load, last_cnt, cnt,
    input  cmp_val, cmp_en, sts_clr, irq_en,
    output ovf_trig, udf_trig, cmp_trig,
    output evt_sts, evt_ovr, irq
  );
endinterface

// File: rtl/timer_evt_ctrl.sv
// Timer event block: overflow/underflow/compare detection,
// trigger pulses, sticky status/overrun flags and a registered irq.
module timer_evt_ctrl #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) (
  input logic             pclk,
  input logic             preset_n,
  timer_evt_ctrl_if.slave bus
);
  localparam int NEV = NUM_CH + 2;
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [NEV-1:0] ev_c;
  logic [NEV-1:0] trig_q;
  logic [NEV-1:0] sts_q;
  logic [NEV-1:0] ovr_q;
  logic           irq_q;

  // Event conditions from the current and previous counter samples.
  always_comb begin
    ev_c = '0;
    if (bus.en && !bus.load) begin
      ev_c[0] = !bus.updw && (bus.last_cnt == MAX)
                && (bus.cnt == '0);
      ev_c[1] = bus.updw && (bus.last_cnt == '0)
                && (bus.cnt == MAX);
      for (int i = 0; i < NUM_CH; i++) begin
        ev_c[2+i] = bus.cmp_en[i]
          && (bus.cnt == bus.cmp_val[i*WIDTH +: WIDTH])
          && (bus.cnt != bus.last_cnt);
      end
    end
  end

  // Pulses, sticky flags (set beats clear) and the combined irq.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      trig_q <= '0;
      sts_q  <= '0;
      ovr_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      trig_q <= ev_c;
      sts_q  <= (sts_q & ~bus.sts_clr) | ev_c;
      ovr_q  <= (ovr_q & ~bus.sts_clr)
              | (ev_c & sts_q & ~bus.sts_clr);
      irq_q  <= |(sts_q & bus.irq_en);
    end
  end

  assign bus.ovf_trig = trig_q[0];
  assign bus.udf_trig = trig_q[1];
  assign bus.cmp_trig = trig_q[NEV-1:2];
  assign bus.evt_sts  = sts_q;
  assign bus.evt_ovr  = ovr_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_timer_evt_ctrl.sv
// Randomised bench for timer_evt_ctrl at 8/2 and 16/4,
// compared against a per-event reference model.
module tb_timer_evt_ctrl;
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  timer_evt_ctrl_if #(.WIDTH(8), .NUM_CH(2))  a8 ();
  timer_evt_ctrl_if #(.WIDTH(16), .NUM_CH(4)) a16 ();

  timer_evt_ctrl #(.WIDTH(8), .NUM_CH(2)) u8 (
    .pclk(pclk), .preset_n(preset_n), .bus(a8)
  );
  timer_evt_ctrl #(.WIDTH(16), .NUM_CH(4)) u16 (
    .pclk(pclk), .preset_n(preset_n), .bus(a16)
  );

  int n_chk = 0;
  int n_fail = 0;
  int W[2]  = '{8, 16};
  int NC[2] = '{2, 4};

  logic [63:0] s_last[2], s_cnt[2];
  logic [63:0] s_cmp[2][4];
  bit s_cmpen[2][4];
  bit s_en[2], s_updw[2], s_load[2];
  bit s_clr[2][6], s_ien[2][6];

  bit m_trig[2][6], m_sts[2][6], m_ovr[2][6];
  bit m_irq[2];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mask_of(int d);
    return (64'd1 << W[d]) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_irq[d] = 0;
      for (int k = 0; k < 6; k++) begin
        m_trig[d][k] = 0;
        m_sts[d][k]  = 0;
        m_ovr[d][k]  = 0;
      end
    end
  endtask

  task automatic gen(int d);
    logic [63:0] mk;
    int ch;
    mk = mask_of(d);
    if ($urandom_range(0, 15) == 0) begin
      for (int c = 0; c < NC[d]; c++) begin
        case ($urandom_range(0, 3))
          0: s_cmp[d][c] = 64'h0;
          1: s_cmp[d][c] = 64'h40;
          2: s_cmp[d][c] = mk;
          default: s_cmp[d][c] = {32'h0, $urandom} & mk;
        endcase
        s_cmpen[d][c] = $urandom_range(0, 4) != 0;
      end
    end
    s_en[d]   = $urandom_range(0, 9) != 0;
    s_load[d] = $urandom_range(0, 9) == 0;
    s_updw[d] = $urandom_range(0, 1) == 1;
    ch = $urandom_range(0, NC[d] - 1);
    case ($urandom_range(0, 5))
      0: begin s_last[d] = mk; s_cnt[d] = 0; end
      1: begin s_last[d] = 0; s_cnt[d] = mk; end
      2: begin
        s_cnt[d]  = s_cmp[d][ch];
        s_last[d] = (s_cnt[d] - 64'd1) & mk;
      end
      3: begin
        s_cnt[d]  = s_cmp[d][ch];
        s_last[d] = s_cnt[d];
      end
      default: begin
        s_cnt[d]  = {32'h0, $urandom} & mk;
        s_last[d] = {32'h0, $urandom} & mk;
      end
    endcase
    for (int k = 0; k < NC[d] + 2; k++) begin
      s_clr[d][k] = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 7) == 0)
        s_ien[d][k] = $urandom_range(0, 1) == 1;
    end
  endtask

  task automatic apply();
    a8.en = s_en[0]; a8.updw = s_updw[0]; a8.load = s_load[0];
    a8.last_cnt = s_last[0][7:0]; a8.cnt = s_cnt[0][7:0];
    for (int c = 0; c < 2; c++) begin
      a8.cmp_val[c*8 +: 8] = s_cmp[0][c][7:0];
      a8.cmp_en[c] = s_cmpen[0][c];
    end
    for (int k = 0; k < 4; k++) begin
      a8.sts_clr[k] = s_clr[0][k];
      a8.irq_en[k]  = s_ien[0][k];
    end
    a16.en = s_en[1]; a16.updw = s_updw[1]; a16.load = s_load[1];
    a16.last_cnt = s_last[1][15:0]; a16.cnt = s_cnt[1][15:0];
    for (int c = 0; c < 4; c++) begin
      a16.cmp_val[c*16 +: 16] = s_cmp[1][c][15:0];
      a16.cmp_en[c] = s_cmpen[1][c];
    end
    for (int k = 0; k < 6; k++) begin
      a16.sts_clr[k] = s_clr[1][k];
      a16.irq_en[k]  = s_ien[1][k];
    end
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic step(int d);
    bit ev[6];
    bit live, nirq;
    logic [63:0] mk;
    mk = mask_of(d);
    live = s_en[d] && !s_load[d];
    for (int k = 0; k < 6; k++) ev[k] = 0;
    ev[0] = live && !s_updw[d] && s_last[d] == mk && s_cnt[d] == 0;
    ev[1] = live && s_updw[d] && s_last[d] == 0 && s_cnt[d] == mk;
    for (int c = 0; c < NC[d]; c++)
      ev[2+c] = live && s_cmpen[d][c] && s_cnt[d] == s_cmp[d][c]
                && s_cnt[d] != s_last[d];
    nirq = 0;
    for (int k = 0; k < NC[d] + 2; k++)
      if (m_sts[d][k] && s_ien[d][k]) nirq = 1;
    m_irq[d] = nirq;
    for (int k = 0; k < NC[d] + 2; k++) begin
      m_trig[d][k] = ev[k];
      if (ev[k]) begin
        if (m_sts[d][k] && !s_clr[d][k]) m_ovr[d][k] = 1;
        else if (s_clr[d][k]) m_ovr[d][k] = 0;
        m_sts[d][k] = 1;
      end else if (s_clr[d][k]) begin
        m_sts[d][k] = 0;
        m_ovr[d][k] = 0;
      end
    end
  endtask

  task automatic check_dut(int d, string pfx);
    logic [63:0] e_cmp, e_sts, e_ovr;
    logic [63:0] g_ovf, g_udf, g_cmp, g_sts, g_ovr, g_irq;
    e_cmp = 0; e_sts = 0; e_ovr = 0;
    for (int k = 0; k < NC[d] + 2; k++) begin
      e_sts[k] = m_sts[d][k];
      e_ovr[k] = m_ovr[d][k];
      if (k >= 2) e_cmp[k-2] = m_trig[d][k];
    end
    if (d == 0) begin
      g_ovf = {63'h0, a8.ovf_trig}; g_udf = {63'h0, a8.udf_trig};
      g_cmp = {62'h0, a8.cmp_trig}; g_sts = {60'h0, a8.evt_sts};
      g_ovr = {60'h0, a8.evt_ovr};  g_irq = {63'h0, a8.irq};
    end else begin
      g_ovf = {63'h0, a16.ovf_trig}; g_udf = {63'h0, a16.udf_trig};
      g_cmp = {60'h0, a16.cmp_trig}; g_sts = {58'h0, a16.evt_sts};
      g_ovr = {58'h0, a16.evt_ovr};  g_irq = {63'h0, a16.irq};
    end
    check({pfx, "ovf_trig"}, g_ovf, {63'h0, m_trig[d][0]});
    check({pfx, "udf_trig"}, g_udf, {63'h0, m_trig[d][1]});
    check({pfx, "cmp_trig"}, g_cmp, e_cmp);
    check({pfx, "evt_sts"}, g_sts, e_sts);
    check({pfx, "evt_ovr"}, g_ovr, e_ovr);
    check({pfx, "irq"}, g_irq, {63'h0, m_irq[d]});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_en[d] = 0; s_updw[d] = 0; s_load[d] = 0;
      s_last[d] = 0; s_cnt[d] = 0;
      for (int c = 0; c < 4; c++) begin
        s_cmp[d][c] = (c == 0) ? 64'h40 : 64'h0;
        s_cmpen[d][c] = 1;
      end
      for (int k = 0; k < 6; k++) begin
        s_clr[d][k] = 0;
        s_ien[d][k] = 1;
      end
    end
    apply();
    model_reset();
    repeat (2) @(negedge pclk);
    check_dut(0, "rst8.");
    check_dut(1, "rst16.");
    preset_n = 1'b1;

    for (int it = 0; it < 4000; it++) begin
      @(negedge pclk);
      check_dut(0, "w8.");
      check_dut(1, "w16.");
      if (!preset_n) preset_n = 1'b1;
      if (it == 1500 || it == 3000) begin
        #2 preset_n = 1'b0;
        #1;
        model_reset();
        check_dut(0, "arst8.");
        check_dut(1, "arst16.");
      end else begin
        gen(0);
        gen(1);
        apply();
        step(0);
        step(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
